// File: rtl/tetris_pkg.sv
// Shared Tetris playfield definitions: move-mode encodings, checker FSM states,
// default field/block geometry and the row-major field index helper.
package tetris_pkg;

  localparam int unsigned FIELD_W_DEF = 10;
  localparam int unsigned FIELD_H_DEF = 10;
  localparam int unsigned BLK_DEF     = 3;

  typedef enum logic [1:0] {
    MODE_DOWN    = 2'b00,
    MODE_LEFT    = 2'b01,
    MODE_RIGHT   = 2'b10,
    MODE_OVERLAP = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  // Row-major cell index, bit 0 is the top-left cell.
  function automatic int unsigned field_idx(input int unsigned x,
                                            input int unsigned y,
                                            input int unsigned w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/collision_check_seq_if.sv
// Request/result bundle between the game-control FSM (master) and the
// sequential collision checker (slave).
interface collision_check_seq_if #(
  parameter int unsigned FIELD_W = tetris_pkg::FIELD_W_DEF,
  parameter int unsigned FIELD_H = tetris_pkg::FIELD_H_DEF,
  parameter int unsigned BLK     = tetris_pkg::BLK_DEF
);
  localparam int unsigned XW    = $clog2(FIELD_W);
  localparam int unsigned YW    = $clog2(FIELD_H);
  localparam int unsigned NCELL = BLK * BLK;
  localparam int unsigned IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int unsigned NF    = FIELD_W * FIELD_H;

  logic              start;
  logic [1:0]        mode;
  logic [0:NF-1]     field;
  logic [0:NCELL-1]  block;
  logic [XW-1:0]     block_x;
  logic [YW-1:0]     block_y;
  logic              busy;
  logic              done;
  logic              collide;
  logic              hit_floor;
  logic              hit_wall;
  logic              hit_field;
  logic [IW-1:0]     hit_idx;

  modport master (
    output start, mode, field, block, block_x, block_y,
    input  busy, done, collide, hit_floor, hit_wall, hit_field, hit_idx
  );

  modport slave (
    input  start, mode, field, block, block_x, block_y,
    output busy, done, collide, hit_floor, hit_wall, hit_field, hit_idx
  );

endinterface

// File: rtl/collision_cell_eval.sv
// Single-cell collision test: target position of one block cell after the move
// offset, classified as wall, floor or occupied-field hit.
module collision_cell_eval
  import tetris_pkg::*;
#(
  parameter int unsigned FIELD_W = FIELD_W_DEF,
  parameter int unsigned FIELD_H = FIELD_H_DEF,
  parameter int unsigned BLK     = BLK_DEF,
  localparam int unsigned XW = $clog2(FIELD_W),
  localparam int unsigned YW = $clog2(FIELD_H),
  localparam int unsigned CW = (BLK > 1) ? $clog2(BLK) : 1,
  localparam int unsigned NF = FIELD_W * FIELD_H
) (
  input  logic [XW-1:0]     base_x,
  input  logic [YW-1:0]     base_y,
  input  logic [CW-1:0]     cx,
  input  logic [CW-1:0]     cy,
  input  logic signed [1:0] dx,
  input  logic signed [1:0] dy,
  input  logic [0:NF-1]     field,
  output logic              wall_c,
  output logic              floor_c,
  output logic              field_c
);

  localparam int unsigned TXW = XW + 2;
  localparam int unsigned TYW = YW + 2;
  localparam int unsigned FIW = (NF > 1) ? $clog2(NF) : 1;

  logic signed [TXW-1:0] tx;
  logic signed [TYW-1:0] ty;
  logic                  y_in;
  logic [FIW-1:0]        fidx;

  // Two guard bits keep negative and past-the-edge targets distinct (no wrap).
  always_comb begin
    tx      = $signed(TXW'(base_x)) + $signed(TXW'(cx)) + TXW'(dx);
    ty      = $signed(TYW'(base_y)) + $signed(TYW'(cy)) + TYW'(dy);
    wall_c  = tx[TXW-1] || (tx >= $signed(TXW'(FIELD_W)));
    floor_c = (ty >= $signed(TYW'(FIELD_H)));
    y_in    = !ty[TYW-1] && !floor_c;
    fidx    = '0;
    field_c = 1'b0;
    if (!wall_c && y_in) begin
      fidx    = FIW'(field_idx(32'($unsigned(tx)), 32'($unsigned(ty)), FIELD_W));
      field_c = field[fidx];
    end
  end

endmodule

// File: rtl/collision_check_seq.sv
// Sequential collision checker: scans one block cell per clock and reports
// collision plus cause. Optional `COLLIDE_EARLY_EXIT_EN ends the scan after the first hit.
module collision_check_seq
  import tetris_pkg::*;
#(
  parameter int unsigned FIELD_W = FIELD_W_DEF,
  parameter int unsigned FIELD_H = FIELD_H_DEF,
  parameter int unsigned BLK     = BLK_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  collision_check_seq_if.slave bus
);

  localparam int unsigned XW    = $clog2(FIELD_W);
  localparam int unsigned YW    = $clog2(FIELD_H);
  localparam int unsigned NCELL = BLK * BLK;
  localparam int unsigned IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int unsigned CW    = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int unsigned NF    = FIELD_W * FIELD_H;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [0:NF-1]    field_q, field_d;
  logic [0:NCELL-1] block_q, block_d;
  logic [XW-1:0]    bx_q, bx_d;
  logic [YW-1:0]    by_q, by_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cx_q, cx_d;
  logic [CW-1:0]    cy_q, cy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             collide_q, collide_d;
  logic             hit_floor_q, hit_floor_d;
  logic             hit_wall_q, hit_wall_d;
  logic             hit_field_q, hit_field_d;
  logic [IW-1:0]    hit_idx_q, hit_idx_d;

  logic signed [1:0] dx_c, dy_c;
  logic              ev_wall_c, ev_floor_c, ev_field_c;
  logic              cell_hit_c, last_c;

  // Move offset for the latched mode.
  always_comb begin
    dx_c = '0;
    dy_c = '0;
    case (mode_q)
      MODE_DOWN:  dy_c = 2'sd1;
      MODE_LEFT:  dx_c = -2'sd1;
      MODE_RIGHT: dx_c = 2'sd1;
      default:    ;
    endcase
  end

  collision_cell_eval #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H),
    .BLK     (BLK)
  ) u_cell_eval (
    .base_x  (bx_q),
    .base_y  (by_q),
    .cx      (cx_q),
    .cy      (cy_q),
    .dx      (dx_c),
    .dy      (dy_c),
    .field   (field_q),
    .wall_c  (ev_wall_c),
    .floor_c (ev_floor_c),
    .field_c (ev_field_c)
  );

  assign cell_hit_c = block_q[idx_q] & (ev_wall_c | ev_floor_c | ev_field_c);
  assign last_c     = (idx_q == IW'(NCELL - 1));

  // Next-state and result logic.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    field_d     = field_q;
    block_d     = block_q;
    bx_d        = bx_q;
    by_d        = by_q;
    idx_d       = idx_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    hit_floor_d = hit_floor_q;
    hit_wall_d  = hit_wall_q;
    hit_field_d = hit_field_q;
    hit_idx_d   = hit_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d      = mode_e'(bus.mode);
          field_d     = bus.field;
          block_d     = bus.block;
          bx_d        = bus.block_x;
          by_d        = bus.block_y;
          idx_d       = '0;
          cx_d        = '0;
          cy_d        = '0;
          hit_floor_d = 1'b0;
          hit_wall_d  = 1'b0;
          hit_field_d = 1'b0;
          hit_idx_d   = '0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cell_hit_c) begin
          hit_floor_d = hit_floor_q | ev_floor_c;
          hit_wall_d  = hit_wall_q  | ev_wall_c;
          hit_field_d = hit_field_q | ev_field_c;
          if (!(hit_floor_q | hit_wall_q | hit_field_q)) hit_idx_d = idx_q;
        end
        if (last_c) begin
          state_d = ST_FIN;
        end else begin
          idx_d = idx_q + IW'(1);
          if (cx_q == CW'(BLK - 1)) begin
            cx_d = '0;
            cy_d = cy_q + CW'(1);
          end else begin
            cx_d = cx_q + CW'(1);
          end
        end
`ifdef COLLIDE_EARLY_EXIT_EN
        if (cell_hit_c) state_d = ST_FIN;
`endif
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    collide_d = hit_floor_d | hit_wall_d | hit_field_d;
    busy_d    = (state_d == ST_SCAN);
    done_d    = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_DOWN;
      field_q     <= '0;
      block_q     <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      idx_q       <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      collide_q   <= 1'b0;
      hit_floor_q <= 1'b0;
      hit_wall_q  <= 1'b0;
      hit_field_q <= 1'b0;
      hit_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      field_q     <= field_d;
      block_q     <= block_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      idx_q       <= idx_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      collide_q   <= collide_d;
      hit_floor_q <= hit_floor_d;
      hit_wall_q  <= hit_wall_d;
      hit_field_q <= hit_field_d;
      hit_idx_q   <= hit_idx_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.collide   = collide_q;
  assign bus.hit_floor = hit_floor_q;
  assign bus.hit_wall  = hit_wall_q;
  assign bus.hit_field = hit_field_q;
  assign bus.hit_idx   = hit_idx_q;

endmodule
